// File: rtl/user_count_pkg.sv
// Shared types for the user event counter bank.
// Run-control state encoding and counter range helper.
package user_count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  function automatic logic [31:0] cnt_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/user_count_ch.sv
// One up/down event counter channel with optional
// edge qualification, wrap/saturate and sticky flags.
module user_count_ch
  import user_count_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int EDGE_MODE = 1
) (
  input  logic             Clk100M,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic up_q;
  logic down_q;
  logic up_ev;
  logic down_ev;

  assign up_ev   = (EDGE_MODE != 0) ? (up & ~up_q) : up;
  assign down_ev = (EDGE_MODE != 0) ? (down & ~down_q) : down;

  // history follows inputs in every state so stale levels never count
  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      up_q   <= up;
      down_q <= down;
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
        unf   <= 1'b0;
      end else if (en) begin
        if (up_ev && !down_ev) begin
          if (count == CNT_MAX) begin
            ovf <= 1'b1;
            if (SATURATE == 0) count <= '0;
          end else begin
            count <= count + ONE;
          end
        end else if (down_ev && !up_ev) begin
          if (count == '0) begin
            unf <= 1'b1;
            if (SATURATE == 0) count <= CNT_MAX;
          end else begin
            count <= count - ONE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/user_count_bank.sv
// Bank of NUM_CH up/down event counters under a
// shared start/stop run-control FSM.
module user_count_bank
  import user_count_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int EDGE_MODE = 1
) (
  input  logic                    Clk100M,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       down,
  output logic                    running,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       unf
);

  state_t state_q;
  state_t state_d;
  logic   en;

  always_ff @(posedge Clk100M or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (stop) state_d = HOLD;
      HOLD:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign running = (state_q == RUN);

  // events coincident with start or stop are dropped
  assign en = running & ~start & ~stop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    user_count_ch #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE),
      .EDGE_MODE(EDGE_MODE)
    ) u_ch (
      .Clk100M(Clk100M),
      .rst_n  (rst_n),
      .clr    (start),
      .en     (en),
      .up     (up[i]),
      .down   (down[i]),
      .count  (count[i*WIDTH +: WIDTH]),
      .ovf    (ovf[i]),
      .unf    (unf[i])
    );
  end

endmodule
